// File: rtl/alu_pkg.sv
// Purpose : shared definitions for the ALU result serializer (FSM states, header nibble, byte count).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: state_t encoding, HDR_NIBBLE constant, nbytes() helper deriving data bytes per frame.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_CHK  = 2'd3
   } state_t;

   // Upper nibble of every frame header byte.
   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   // Data bytes carried per frame for a given result width (width is a multiple of 8).
   function automatic int nbytes(input int arith_width);
      return arith_width / 8;
   endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Purpose : bundles the result capture, byte stream and status signals of the serializer.
// Latency : n/a (wiring only).
// Backpr. : TX_READY from the sink stalls TX_DATA/TX_VALID; result side has no backpressure.
// Ports   : Arith_OUT/Carry_OUT/Arith_Flag result in; TX_DATA/TX_VALID/TX_READY byte stream;
//           FIFO_FULL/OVERFLOW/BUSY status. slave = serializer view, master = environment view.
interface alu_result_serializer_if #(
   parameter int ARITH_WIDTH = 32
);
   logic [ARITH_WIDTH-1:0] Arith_OUT;
   logic                   Carry_OUT;
   logic                   Arith_Flag;
   logic [7:0]             TX_DATA;
   logic                   TX_VALID;
   logic                   TX_READY;
   logic                   FIFO_FULL;
   logic                   OVERFLOW;
   logic                   BUSY;

   modport slave (
      input  Arith_OUT, Carry_OUT, Arith_Flag, TX_READY,
      output TX_DATA, TX_VALID, FIFO_FULL, OVERFLOW, BUSY
   );

   modport master (
      output Arith_OUT, Carry_OUT, Arith_Flag, TX_READY,
      input  TX_DATA, TX_VALID, FIFO_FULL, OVERFLOW, BUSY
   );
endinterface

// File: rtl/alu_result_fifo.sv
// Purpose : synchronous FIFO holding captured {carry, result} entries.
// Latency : a push at edge N is readable (empty=0, dout valid) from edge N+1.
// Backpr. : push while full is ignored unless a pop happens in the same cycle.
// Ports   : clk/rst (sync, active-low); push/din write side; pop/dout read side (dout is
//           show-ahead); full is registered alongside the pointers, empty is decoded from them.
module alu_result_fifo #(
   parameter int DW    = 33,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic          push_ok, pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push_ok};
   assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop_ok};

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_result_serializer.sv
// Purpose : captures flagged ALU results into a FIFO and emits each as a byte frame
//           (header {A,000,carry}, result bytes MSB first, optional XOR checksum byte).
// Latency : flag at edge N with FSM idle and FIFO empty -> header with TX_VALID=1 after edge N+1.
// Backpr. : TX_DATA/TX_VALID hold while TX_READY=0; results arriving with the FIFO full are dropped
//           and flagged on sticky OVERFLOW. TX_VALID never depends combinationally on TX_READY.
// Ports   : CLK, RST (sync, active-low), bus (alu_result_serializer_if.slave).
// Config  : define RESULT_CHECKSUM_EN to append the checksum byte (adds the CHK state).
module alu_result_serializer
   import alu_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int ARITH_WIDTH = 2 * WIDTH,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                    CLK,
   input logic                    RST,
   alu_result_serializer_if.slave bus
);
   localparam int NBYTES = nbytes(ARITH_WIDTH);
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int EW     = ARITH_WIDTH + 1;

   logic [EW-1:0]    fifo_dout;
   logic             fifo_full, fifo_empty, pop;

   state_t           state, state_n;
   logic [EW-1:0]    frame, frame_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       tx_data, tx_data_n;
   logic             tx_valid, tx_valid_n;
   logic             overflow;
   logic             xfer, frame_done;
`ifdef RESULT_CHECKSUM_EN
   logic [7:0]       chk, chk_n;
`endif

   alu_result_fifo #(
      .DW    (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (bus.Arith_Flag),
      .pop   (pop),
      .din   ({bus.Carry_OUT, bus.Arith_OUT}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   function automatic logic [7:0] hdr_byte(input logic carry);
      return {HDR_NIBBLE, 3'b000, carry};
   endfunction

   function automatic logic [7:0] data_byte(input logic [EW-1:0] f, input logic [CNT_W-1:0] idx);
      return f[8*idx +: 8];
   endfunction

   assign xfer = tx_valid && bus.TX_READY;

   always_comb begin
      state_n    = state;
      frame_n    = frame;
      cnt_n      = cnt;
      tx_data_n  = tx_data;
      tx_valid_n = tx_valid;
      pop        = 1'b0;
      frame_done = 1'b0;
`ifdef RESULT_CHECKSUM_EN
      chk_n      = chk;
`endif
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               frame_n    = fifo_dout;
               tx_data_n  = hdr_byte(fifo_dout[EW-1]);
               tx_valid_n = 1'b1;
               state_n    = ST_HDR;
            end
         end
         ST_HDR: begin
            // Entered with TX_VALID low after a back-to-back reload: raise the header one cycle later.
            if (!tx_valid) begin
               tx_data_n  = hdr_byte(frame[EW-1]);
               tx_valid_n = 1'b1;
            end else if (xfer) begin
               tx_data_n = data_byte(frame, CNT_W'(NBYTES - 1));
               cnt_n     = CNT_W'(NBYTES - 1);
               state_n   = ST_DATA;
`ifdef RESULT_CHECKSUM_EN
               chk_n     = tx_data;
`endif
            end
         end
         ST_DATA: begin
            if (xfer) begin
               if (cnt != '0) begin
                  cnt_n     = cnt - 1'b1;
                  tx_data_n = data_byte(frame, cnt - 1'b1);
`ifdef RESULT_CHECKSUM_EN
                  chk_n     = chk ^ tx_data;
`endif
               end else begin
`ifdef RESULT_CHECKSUM_EN
                  tx_data_n = chk ^ tx_data;
                  state_n   = ST_CHK;
`else
                  frame_done = 1'b1;
`endif
               end
            end
         end
`ifdef RESULT_CHECKSUM_EN
         ST_CHK: begin
            if (xfer) begin
               frame_done = 1'b1;
            end
         end
`endif
         default: state_n = ST_IDLE;
      endcase

      // Popping on the final handshake frees a slot the same cycle, so a push into a full FIFO survives.
      if (frame_done) begin
         tx_valid_n = 1'b0;
         if (!fifo_empty) begin
            pop     = 1'b1;
            frame_n = fifo_dout;
            state_n = ST_HDR;
         end else begin
            state_n = ST_IDLE;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= ST_IDLE;
         frame    <= '0;
         cnt      <= '0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         overflow <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
         chk      <= 8'h00;
`endif
      end else begin
         state    <= state_n;
         frame    <= frame_n;
         cnt      <= cnt_n;
         tx_data  <= tx_data_n;
         tx_valid <= tx_valid_n;
`ifdef RESULT_CHECKSUM_EN
         chk      <= chk_n;
`endif
         if (bus.Arith_Flag && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   assign bus.TX_DATA   = tx_data;
   assign bus.TX_VALID  = tx_valid;
   assign bus.FIFO_FULL = fifo_full;
   assign bus.OVERFLOW  = overflow;
   assign bus.BUSY      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Purpose : self-checking bench for alu_result_serializer (table vectors plus multi-cycle sequences).
// Latency : n/a.
// Backpr. : drives TX_READY as always-on, toggling, random or held low per phase.
module tb_alu_result_serializer;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   alu_result_serializer_if #(.ARITH_WIDTH(32)) bus ();

   alu_result_serializer #(
      .WIDTH       (16),
      .ARITH_WIDTH (32),
      .FIFO_DEPTH  (4)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

`ifdef RESULT_CHECKSUM_EN
   localparam int FRAME_LEN = 6;
`else
   localparam int FRAME_LEN = 5;
`endif

   typedef struct {
      logic [31:0] arith;
      logic        carry;
      int          rdy_mode;   // 0 ready, 1 toggle, 2 random, 3 held low
      logic [7:0]  exp_hdr;
      logic [31:0] exp_data;
      logic [7:0]  exp_chk;
   } vec_t;

   vec_t       vecs [5];
   int         checks;
   int         errors;
   int         xfer_cnt;
   int         rdy_mode;
   logic [7:0] exp_q [$];
   logic       stall_prev;
   logic [7:0] stall_dat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: header, four bytes MSB first, optional XOR of everything before it.
   task automatic push_model(input logic [31:0] d, input logic c);
      logic [7:0] h;
      h = {4'hA, 3'b000, c};
      exp_q.push_back(h);
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
`ifdef RESULT_CHECKSUM_EN
      exp_q.push_back(h ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
`endif
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.BUSY) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout bytes_left %0d expected 0", exp_q.size());
      end
   endtask

   task automatic wait_xfers(input int target, input string name);
      int n;
      n = 0;
      while (xfer_cnt < target && n < 60) begin
         @(negedge CLK);
         n++;
      end
      check(name, xfer_cnt, target);
   endtask

   initial begin
      int start;
      logic [31:0] d;

      bus.Arith_OUT  = '0;
      bus.Carry_OUT  = 1'b0;
      bus.Arith_Flag = 1'b0;
      bus.TX_READY   = 1'b0;
      rdy_mode   = 0;
      checks     = 0;
      errors     = 0;
      xfer_cnt   = 0;
      stall_prev = 1'b0;
      stall_dat  = 8'h00;

      vecs[0] = '{32'h1234_5678, 1'b1, 0, 8'hA1, 32'h1234_5678, 8'hA9};
      vecs[1] = '{32'hFFFF_FFFF, 1'b0, 0, 8'hA0, 32'hFFFF_FFFF, 8'hA0};
      vecs[2] = '{32'hDEAD_BEEF, 1'b0, 1, 8'hA0, 32'hDEAD_BEEF, 8'h82};
      vecs[3] = '{32'h0000_0000, 1'b1, 2, 8'hA1, 32'h0000_0000, 8'hA1};
      vecs[4] = '{32'h8000_0001, 1'b1, 1, 8'hA1, 32'h8000_0001, 8'h20};

      fork
         forever begin
            @(negedge CLK);
            case (rdy_mode)
               0:       bus.TX_READY = 1'b1;
               1:       bus.TX_READY = ~bus.TX_READY;
               2:       bus.TX_READY = 1'($urandom_range(0, 1));
               default: bus.TX_READY = 1'b0;
            endcase
         end
         forever begin
            @(negedge CLK);
            #3;
            if (RST && stall_prev) begin
               checks++;
               if (!bus.TX_VALID || bus.TX_DATA !== stall_dat) begin
                  errors++;
                  $display("FAIL stall_hold got v%0b %02h expected v1 %02h", bus.TX_VALID, bus.TX_DATA, stall_dat);
               end
            end
            if (RST && bus.TX_VALID && bus.TX_READY) begin
               xfer_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL tx_byte got %02h expected no byte", bus.TX_DATA);
               end else begin
                  d[7:0] = exp_q.pop_front();
                  if (bus.TX_DATA !== d[7:0]) begin
                     errors++;
                     $display("FAIL tx_byte got %02h expected %02h", bus.TX_DATA, d[7:0]);
                  end
               end
            end
            stall_prev = RST && bus.TX_VALID && !bus.TX_READY;
            stall_dat  = bus.TX_DATA;
         end
      join_none

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_valid", 32'(bus.TX_VALID), 0);
      check("rst_data", 32'(bus.TX_DATA), 0);
      check("rst_busy", 32'(bus.BUSY), 0);
      check("rst_ovf", 32'(bus.OVERFLOW), 0);
      check("rst_full", 32'(bus.FIFO_FULL), 0);
      RST = 1'b1;
      @(negedge CLK);

      // Table vectors: single frames with latency check and varying sink readiness
      for (int i = 0; i < 5; i++) begin
         rdy_mode = vecs[i].rdy_mode;
         repeat (2) @(negedge CLK);
         d = vecs[i].exp_data;
         exp_q.push_back(vecs[i].exp_hdr);
         exp_q.push_back(d[31:24]);
         exp_q.push_back(d[23:16]);
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
`ifdef RESULT_CHECKSUM_EN
         exp_q.push_back(vecs[i].exp_chk);
`endif
         bus.Arith_OUT  = vecs[i].arith;
         bus.Carry_OUT  = vecs[i].carry;
         bus.Arith_Flag = 1'b1;
         @(negedge CLK);
         bus.Arith_Flag = 1'b0;
         check("lat_n1_valid", 32'(bus.TX_VALID), 0);
         @(negedge CLK);
         check("lat_n2_valid", 32'(bus.TX_VALID), 1);
         check("lat_n2_hdr", 32'(bus.TX_DATA), 32'(vecs[i].exp_hdr));
         wait_idle(200);
      end

      // Overflow: one frame stalled in the frame register, then six results into a 4-deep FIFO
      rdy_mode = 3;
      repeat (2) @(negedge CLK);
      push_model(32'hCAFE_0000, 1'b0);
      bus.Arith_OUT  = 32'hCAFE_0000;
      bus.Carry_OUT  = 1'b0;
      bus.Arith_Flag = 1'b1;
      @(negedge CLK);
      bus.Arith_Flag = 1'b0;
      @(negedge CLK);
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) push_model(32'(k), 1'b0);
         bus.Arith_OUT  = 32'(k);
         bus.Arith_Flag = 1'b1;
         @(negedge CLK);
         if (k == 3) check("ovf_full_at3", 32'(bus.FIFO_FULL), 0);
         if (k == 4) check("ovf_full_at4", 32'(bus.FIFO_FULL), 1);
         if (k == 4) check("ovf_clear_at4", 32'(bus.OVERFLOW), 0);
         if (k == 5) check("ovf_set_at5", 32'(bus.OVERFLOW), 1);
      end
      bus.Arith_Flag = 1'b0;
      rdy_mode = 0;
      wait_idle(400);
      check("ovf_sticky", 32'(bus.OVERFLOW), 1);

      // Reset two data bytes into a frame with two entries queued behind it
      start = xfer_cnt;
      for (int k = 0; k < 3; k++) begin
         push_model(32'hA5A5_0000 + 32'(k), 1'b1);
         bus.Arith_OUT  = 32'hA5A5_0000 + 32'(k);
         bus.Carry_OUT  = 1'b1;
         bus.Arith_Flag = 1'b1;
         @(negedge CLK);
      end
      bus.Arith_Flag = 1'b0;
      wait_xfers(start + 3, "rst_mid_reach");
      RST = 1'b0;
      exp_q.delete();
      @(negedge CLK);
      check("rst_mid_valid", 32'(bus.TX_VALID), 0);
      check("rst_mid_busy", 32'(bus.BUSY), 0);
      check("rst_mid_ovf", 32'(bus.OVERFLOW), 0);
      check("rst_mid_full", 32'(bus.FIFO_FULL), 0);
      RST = 1'b1;
      start = xfer_cnt;
      repeat (20) @(negedge CLK);
      check("rst_mid_quiet", xfer_cnt, start);
      push_model(32'h0BAD_F00D, 1'b0);
      bus.Arith_OUT  = 32'h0BAD_F00D;
      bus.Carry_OUT  = 1'b0;
      bus.Arith_Flag = 1'b1;
      @(negedge CLK);
      bus.Arith_Flag = 1'b0;
      wait_idle(200);

      // Push on the cycle the last byte is accepted while the FIFO is full
      rdy_mode = 3;
      repeat (2) @(negedge CLK);
      for (int k = 0; k < 5; k++) begin
         push_model(32'h1111_1111 * 32'(k + 1), k[0]);
         bus.Arith_OUT  = 32'h1111_1111 * 32'(k + 1);
         bus.Carry_OUT  = k[0];
         bus.Arith_Flag = 1'b1;
         @(negedge CLK);
      end
      bus.Arith_Flag = 1'b0;
      check("t6_full_before", 32'(bus.FIFO_FULL), 1);
      rdy_mode = 0;
      start = xfer_cnt;
      wait_xfers(start + FRAME_LEN - 1, "t6_reach_last");
      push_model(32'h7777_0000, 1'b1);
      bus.Arith_OUT  = 32'h7777_0000;
      bus.Carry_OUT  = 1'b1;
      bus.Arith_Flag = 1'b1;
      @(negedge CLK);
      bus.Arith_Flag = 1'b0;
      check("t6_ovf", 32'(bus.OVERFLOW), 0);
      check("t6_full_kept", 32'(bus.FIFO_FULL), 1);
      check("t6_gap", 32'(bus.TX_VALID), 0);
      @(negedge CLK);
      check("t6_next_valid", 32'(bus.TX_VALID), 1);
      check("t6_next_hdr", 32'(bus.TX_DATA), 32'h0000_00A1);
      wait_idle(600);
      check("t6_ovf_end", 32'(bus.OVERFLOW), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
